// File: rtl/esfa_cell_controller.sv
// Initiator for the ESFA cell broadcast bus: one host op at a time, broadcast to all cells,
// reduce per-cell replies to lowest-handle hit + popcount; sequences the two-step ALLOC_WRITE.
module esfa_cell_controller #(
    parameter int unsigned NUM_CELLS = 8,
    parameter int unsigned W         = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [3:0]                        req_op,
    input  logic [W-1:0]                      req_index,
    input  logic [W-1:0]                      req_value,
    input  logic [W-1:0]                      req_meta,
    input  logic                              req_is_meta,
    output logic [7:0]                        cell_selector,
    output logic [W-1:0]                      cell_index,
    output logic [W-1:0]                      cell_value,
    output logic [W-1:0]                      cell_meta,
    output logic                              cell_is_meta,
    input  logic [NUM_CELLS-1:0]              cell_bool,
    input  logic [NUM_CELLS*W-1:0]            cell_result,
    input  logic [NUM_CELLS*W-1:0]            cell_context,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_hit,
    output logic [W-1:0]                      rsp_handle,
    output logic [W-1:0]                      rsp_value,
    output logic [W-1:0]                      rsp_context,
    output logic [$clog2(NUM_CELLS+1)-1:0]    rsp_count,
    output logic                              rsp_err
);

    localparam int unsigned HW    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_CELLS + 1);

    localparam logic [7:0] SEL_IDLE      = 8'hFF;
    localparam logic [7:0] SEL_WRITE     = 8'h00;
    localparam logic [7:0] SEL_FIND_FREE = 8'h05;
    localparam logic [3:0] OP_ALLOC      = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DRIVE2,
        S_SAMPLE2,
        S_RESP
    } state_t;

    state_t state;
    logic   is_alloc;

    logic             enc_hit;
    logic [HW-1:0]    enc_handle;
    logic [W-1:0]     enc_value;
    logic [W-1:0]     enc_context;
    logic [CNT_W-1:0] enc_count;

    logic             sel_bool;
    logic [W-1:0]     sel_result;
    logic [W-1:0]     sel_context;

    // Lowest set bit wins: scan from the top so lower handles overwrite.
    always_comb begin
        enc_hit     = 1'b0;
        enc_handle  = '0;
        enc_value   = '0;
        enc_context = '0;
        enc_count   = '0;
        for (int i = int'(NUM_CELLS) - 1; i >= 0; i--) begin
            if (cell_bool[i]) begin
                enc_hit     = 1'b1;
                enc_handle  = HW'(i);
                enc_value   = cell_result[i*W +: W];
                enc_context = cell_context[i*W +: W];
            end
            enc_count = enc_count + CNT_W'(cell_bool[i]);
        end
    end

    // Reply of the cell just written by ALLOC_WRITE (its handle is held in rsp_handle).
    always_comb begin
        sel_bool    = 1'b0;
        sel_result  = '0;
        sel_context = '0;
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            if (rsp_handle == W'(i)) begin
                sel_bool    = cell_bool[i];
                sel_result  = cell_result[i*W +: W];
                sel_context = cell_context[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            is_alloc      <= 1'b0;
            req_ready     <= 1'b1;
            cell_selector <= SEL_IDLE;
            cell_index    <= '0;
            cell_value    <= '0;
            cell_meta     <= '0;
            cell_is_meta  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_handle    <= '0;
            rsp_value     <= '0;
            rsp_context   <= '0;
            rsp_count     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_op > OP_ALLOC) begin
                            // Illegal opcode: answer immediately, bus untouched.
                            state       <= S_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_hit     <= 1'b0;
                            rsp_handle  <= '0;
                            rsp_value   <= '0;
                            rsp_context <= '0;
                            rsp_count   <= '0;
                        end else begin
                            state         <= S_DRIVE;
                            is_alloc      <= (req_op == OP_ALLOC);
                            cell_selector <= (req_op == OP_ALLOC) ? SEL_FIND_FREE : 8'(req_op);
                            cell_index    <= req_index;
                            cell_value    <= req_value;
                            cell_meta     <= req_meta;
                            cell_is_meta  <= req_is_meta;
                        end
                    end
                end
                S_DRIVE: begin
                    cell_selector <= SEL_IDLE;
                    state         <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    rsp_err <= 1'b0;
                    if (is_alloc && enc_hit) begin
                        // Free cell found: write it, tagging metadata with its handle.
                        state         <= S_DRIVE2;
                        rsp_handle    <= W'(enc_handle);
                        cell_selector <= SEL_WRITE;
                        cell_meta     <= W'(enc_handle);
                        cell_is_meta  <= 1'b1;
                    end else begin
                        state       <= S_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_hit     <= enc_hit;
                        rsp_handle  <= W'(enc_handle);
                        rsp_value   <= enc_value;
                        rsp_context <= enc_context;
                        rsp_count   <= enc_count;
                    end
                end
                S_DRIVE2: begin
                    cell_selector <= SEL_IDLE;
                    state         <= S_SAMPLE2;
                end
                S_SAMPLE2: begin
                    state       <= S_RESP;
                    rsp_valid   <= 1'b1;
                    rsp_hit     <= sel_bool;
                    rsp_value   <= sel_result;
                    rsp_context <= sel_context;
                    rsp_count   <= enc_count;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state        <= S_IDLE;
                        rsp_valid    <= 1'b0;
                        req_ready    <= 1'b1;
                        cell_index   <= '0;
                        cell_value   <= '0;
                        cell_meta    <= '0;
                        cell_is_meta <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    req_ready     <= 1'b1;
                    cell_selector <= SEL_IDLE;
                    rsp_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule
